// File: rtl/clk_freq_monitor.sv
// Counts synchronized rising edges of mon_clk_in over a GATE_CYCLES window of clk.
// Reports count, in-range and stopped verdicts each window and raises a sticky fault.
module clk_freq_monitor #(
  parameter int GATE_CYCLES = 27000,
  parameter int EXP_COUNT   = 6750,
  parameter int TOL         = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk_in,
  input  logic             enable,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             in_range,
  output logic             stopped,
  output logic             fault,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);

  typedef enum logic [1:0] {IDLE, GATE, EVAL} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic [1:0]        prime;
  logic [GW-1:0]     gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  final_cnt;
  logic              mon_edge;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]    mag;
  logic              verdict;
  logic              load_gate;
  logic              eval_load;
  logic              fault_set;

  assign mon_edge = s2 & ~s3;

  // Count that includes an edge seen in the current cycle, saturating at all-ones.
  always_comb begin
    final_cnt = edge_cnt;
    if (mon_edge && !(&edge_cnt))
      final_cnt = edge_cnt + 1'b1;
    diff    = $signed({1'b0, final_cnt}) - $signed((CNT_W+1)'(EXP_COUNT));
    mag     = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    verdict = (mag <= (CNT_W+1)'(TOL)) && !(&final_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && prime == 2'd3) state_nxt = GATE;
      GATE:    if (!enable) state_nxt = IDLE;
               else if (gate_cnt == '0) state_nxt = EVAL;
      EVAL:    state_nxt = enable ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_gate = (state != GATE) && (state_nxt == GATE);
    eval_load = (state == GATE) && (state_nxt == EVAL);
    busy      = (state != IDLE);
    // A failing verdict also blocks a clear arriving during the EVAL cycle itself.
    fault_set = (eval_load && !verdict) || (state == EVAL && !in_range);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      prime      <= 2'd0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      stopped    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      s1 <= mon_clk_in;
      s2 <= s1;
      s3 <= s2;
      if (prime != 2'd3)
        prime <= prime + 1'b1;

      if (load_gate)
        gate_cnt <= GW'(GATE_CYCLES - 1);
      else if (state == GATE && gate_cnt != '0)
        gate_cnt <= gate_cnt - 1'b1;

      if (state == GATE)
        edge_cnt <= final_cnt;
      else
        edge_cnt <= '0;

      meas_valid <= eval_load;
      if (eval_load) begin
        meas_count <= final_cnt;
        in_range   <= verdict;
        stopped    <= (final_cnt == '0);
      end

      if (fault_set)
        fault <= 1'b1;
      else if (fault_clr)
        fault <= 1'b0;
    end
  end

endmodule
